operand_fetch_stage: RTL and testbench

- Decode/operand stage directly upstream of the execute ALU.
- Holds the 32-entry integer register file and accepts writeback from the later stage.
- Reads rs1/rs2 for each incoming instruction and presents rs1, rs2 and inst to the ALU through an output pipeline register.
- Uses a valid/ready handshake on both sides, with stall, flush and writeback bypass.

---
 rtl/operand_fetch_stage.sv | 80 ++++++++
 tb/tb_operand_fetch_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: 32-entry register file with writeback bypass, feeding the
// ALU through a valid/ready output register with stall refresh and flush.
module operand_fetch_stage #(
  parameter int unsigned n    = 32,
  parameter int unsigned NREG = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_inst,
  input  logic          flush,
  input  logic          wb_en,
  input  logic [4:0]    wb_rd,
  input  logic [n-1:0]  wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [n-1:0]  rs1,
  output logic [n-1:0]  rs2,
  output logic [31:0]   inst
);

  localparam int unsigned IDX_W = 5;

  logic [n-1:0]     rf [NREG];
  logic [IDX_W-1:0] src1_c, src2_c;
  logic [IDX_W-1:0] held1_c, held2_c;
  logic [n-1:0]     rd1_c, rd2_c;
  logic             wb_hit_c;
  logic             load_c;

  assign src1_c   = in_inst[19:15];
  assign src2_c   = in_inst[24:20];
  assign held1_c  = inst[19:15];
  assign held2_c  = inst[24:20];
  assign wb_hit_c = wb_en && (wb_rd != '0);
  assign in_ready = !out_valid || out_ready;
  assign load_c   = in_valid && in_ready && !flush;

  // Register file read with same-cycle writeback forwarding; x0 is hardwired zero.
  always_comb begin
    rd1_c = rf[src1_c];
    rd2_c = rf[src2_c];
    if (src1_c == '0)                      rd1_c = '0;
    else if (wb_hit_c && wb_rd == src1_c)  rd1_c = wb_data;
    if (src2_c == '0)                      rd2_c = '0;
    else if (wb_hit_c && wb_rd == src2_c)  rd2_c = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else if (wb_hit_c) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // Output register: flush beats load, load beats drain, a held entry tracks writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      rs1       <= '0;
      rs2       <= '0;
      inst      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_c) begin
      out_valid <= 1'b1;
      rs1       <= rd1_c;
      rs2       <= rd2_c;
      inst      <= in_inst;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      if (wb_hit_c && wb_rd == held1_c) rs1 <= wb_data;
      if (wb_hit_c && wb_rd == held2_c) rs2 <= wb_data;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios plus randomized traffic
// compared against a transaction-level model of the register file and output slot.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, wb_en, out_valid, out_ready;
  logic [31:0] in_inst, wb_data, rs1, rs2, inst;
  logic [4:0]  wb_rd;

  int checks   = 0;
  int failures = 0;

  // model state: architectural registers and the single slot presented to the ALU
  logic [31:0] m_rf [32];
  bit          m_valid;
  logic [31:0] m_rs1, m_rs2, m_inst;

  operand_fetch_stage #(.n(32), .NREG(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .rs1(rs1), .rs2(rs2), .inst(inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] a, input logic [4:0] b);
    return {7'($urandom), b, a, 15'($urandom)};
  endfunction

  // value an instruction sees for source index idx this cycle
  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_en && wb_rd == idx) return wb_data;
    return m_rf[idx];
  endfunction

  // advance the model by one clock edge using the currently driven inputs, then clock the DUT
  task automatic tick();
    bit accept;
    accept = (!m_valid || out_ready) && in_valid && !flush;
    if (rst) begin
      foreach (m_rf[i]) m_rf[i] = 32'd0;
      m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_inst = 0;
    end else begin
      if (flush) m_valid = 0;
      else if (accept) begin
        m_rs1 = m_read(in_inst[19:15]); m_rs2 = m_read(in_inst[24:20]);
        m_inst = in_inst; m_valid = 1;
      end else if (m_valid && out_ready) m_valid = 0;
      else if (m_valid && wb_en && wb_rd != 0) begin
        if (wb_rd == m_inst[19:15]) m_rs1 = wb_data;
        if (wb_rd == m_inst[24:20]) m_rs2 = wb_data;
      end
      if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
    end
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    rst = 0; in_valid = 0; flush = 0; wb_en = 0; wb_rd = 0; wb_data = 0; out_ready = 1;
    in_inst = 0;
  endtask

  task automatic test_reset();
    quiet(); rst = 1; tick(); tick(); rst = 0; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (rs1 !== 32'd0 || rs2 !== 32'd0) begin failures++; $display("FAIL reset_ops got=%h/%h exp=0/0", rs1, rs2); end
    checks++; if (inst !== 32'd0) begin failures++; $display("FAIL reset_inst got=%h exp=0", inst); end
    out_ready = 0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    out_ready = 1;
  endtask

  task automatic test_write_read();
    quiet(); wb_en = 1; wb_rd = 5; wb_data = 32'h0000_00AA; tick();
    quiet(); in_valid = 1; in_inst = {7'h00, 5'd0, 5'd5, 3'b000, 5'd1, 7'h33}; tick();
    quiet();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL wr_valid got=%b exp=1", out_valid); end
    checks++; if (rs1 !== 32'hAA || rs2 !== 32'd0) begin failures++; $display("FAIL wr_ops got=%h/%h exp=000000aa/0", rs1, rs2); end
    tick();
  endtask

  task automatic test_bypass();
    quiet(); wb_en = 1; wb_rd = 7; wb_data = 32'h1234; in_valid = 1; in_inst = mk(5'd7, 5'd7); tick();
    quiet();
    checks++; if (rs1 !== 32'h1234 || rs2 !== 32'h1234) begin failures++; $display("FAIL bypass got=%h/%h exp=1234/1234", rs1, rs2); end
    in_valid = 1; in_inst = mk(5'd7, 5'd0); tick(); quiet();
    checks++; if (rs1 !== 32'h1234) begin failures++; $display("FAIL bypass_store got=%h exp=1234", rs1); end
    tick();
  endtask

  task automatic test_stall_refresh();
    quiet(); out_ready = 0; in_valid = 1; in_inst = mk(5'd1, 5'd3); tick();
    quiet(); out_ready = 0; wb_en = 1; wb_rd = 3; wb_data = 32'hDEAD_BEEF; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
    tick(); quiet(); out_ready = 0; #1;
    checks++; if (rs2 !== 32'hDEAD_BEEF || out_valid !== 1'b1) begin failures++; $display("FAIL stall_refresh got=%h v=%b exp=deadbeef v=1", rs2, out_valid); end
    checks++; if (rs1 !== m_rs1) begin failures++; $display("FAIL stall_rs1 got=%h exp=%h", rs1, m_rs1); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready2 got=%b exp=0", in_ready); end
    out_ready = 1; tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] sent [4];
    quiet();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_inst = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      in_inst[31:25] = 7'(i + 1); sent[i] = in_inst; tick();
      checks++;
      if (out_valid !== 1'b1 || inst !== sent[i] || rs1 !== m_rs1 || rs2 !== m_rs2) begin
        failures++; $display("FAIL b2b_%0d got v=%b i=%h %h/%h exp v=1 i=%h %h/%h", i, out_valid, inst, rs1, rs2, sent[i], m_rs1, m_rs2);
      end
    end
    quiet(); tick();
  endtask

  task automatic test_flush();
    quiet(); out_ready = 0; in_valid = 1; in_inst = mk(5'd2, 5'd2); tick();
    quiet(); out_ready = 0; in_valid = 1; flush = 1; in_inst = mk(5'd4, 5'd4);
    wb_en = 1; wb_rd = 9; wb_data = 32'd5; tick();
    quiet();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    in_valid = 1; in_inst = mk(5'd9, 5'd0); tick(); quiet();
    checks++; if (rs1 !== 32'd5) begin failures++; $display("FAIL flush_wb got=%h exp=5", rs1); end
    tick();
  endtask

  task automatic test_x0();
    quiet(); wb_en = 1; wb_rd = 0; wb_data = 32'hFFFF_FFFF; in_valid = 1; in_inst = mk(5'd0, 5'd0); tick();
    quiet();
    checks++; if (rs1 !== 32'd0 || rs2 !== 32'd0) begin failures++; $display("FAIL x0_same got=%h/%h exp=0/0", rs1, rs2); end
    in_valid = 1; in_inst = mk(5'd0, 5'd0); tick(); quiet();
    checks++; if (rs1 !== 32'd0) begin failures++; $display("FAIL x0_later got=%h exp=0", rs1); end
    tick();
  endtask

  task automatic test_rst_stall();
    quiet(); wb_en = 1; wb_rd = 7; wb_data = 32'h7777; tick();
    quiet(); out_ready = 0; in_valid = 1; in_inst = mk(5'd7, 5'd7); tick();
    quiet(); out_ready = 0; rst = 1; tick(); rst = 0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_stall_valid got=%b exp=0", out_valid); end
    in_valid = 1; in_inst = mk(5'd7, 5'd7); tick(); quiet();
    checks++; if (rs1 !== 32'd0 || rs2 !== 32'd0) begin failures++; $display("FAIL rst_stall_x7 got=%h/%h exp=0/0", rs1, rs2); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 9) == 0;
      wb_en = $urandom_range(0, 1) != 0;
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      in_inst = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      #1;
      checks++;
      if (in_ready !== (!m_valid || out_ready)) begin
        failures++; $display("FAIL rand_in_ready c=%0d got=%b exp=%b", c, in_ready, !m_valid || out_ready);
      end
      tick();
      checks++;
      if (out_valid !== m_valid || (m_valid && (rs1 !== m_rs1 || rs2 !== m_rs2 || inst !== m_inst))) begin
        failures++; $display("FAIL rand_out c=%0d got v=%b %h/%h i=%h exp v=%b %h/%h i=%h", c, out_valid, rs1, rs2, inst, m_valid, m_rs1, m_rs2, m_inst);
      end
    end
    quiet();
  endtask

  initial begin
    quiet();
    m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_inst = 0;
    foreach (m_rf[i]) m_rf[i] = 32'd0;
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_bypass();
    test_stall_refresh();
    test_back_to_back();
    test_flush();
    test_x0();
    test_rst_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
